// File: rtl/escalonador_pkg.sv
// Shared encodings for the frame scheduler: pet states, scheduler FSM states
// and the per-state frame-count table.
package escalonador_pkg;

  typedef enum logic [3:0] {
    EST_IDLE       = 4'd0,
    EST_DORMINDO   = 4'd1,
    EST_COMENDO    = 4'd2,
    EST_DANDO_AULA = 4'd3,
    EST_MORTO      = 4'd4
  } estado_pet_e;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    LER    = 2'd1,
    ENVIAR = 2'd2
  } fsm_e;

  // Out-of-range pet states are treated as IDLE.
  function automatic logic [3:0] saneia_estado(input logic [3:0] e);
    return (e > 4'(EST_MORTO)) ? 4'(EST_IDLE) : e;
  endfunction

  function automatic logic [2:0] num_quadros(input logic [3:0] e);
    case (e)
      4'(EST_DORMINDO): return 3'd2;
      4'(EST_COMENDO):  return 3'd3;
      4'(EST_MORTO):    return 3'd1;
      default:          return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/escalonador_quadros_contador.sv
// contador_quadros: frame index per pet state plus the estado of the last
// started frame; restarts the index when the state changes.
module contador_quadros
  import escalonador_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inicio,
  input  logic       avancar,
  input  logic [3:0] estado_in,
  output logic [3:0] estado_out,
  output logic [1:0] quadro
);

  logic [3:0] estado_q, estado_d;
  logic [1:0] quadro_q, quadro_d;

  always_comb begin
    estado_d = estado_q;
    quadro_d = quadro_q;
    if (inicio) begin
      estado_d = estado_in;
      if (estado_in != estado_q) quadro_d = 2'd0;
    end else if (avancar) begin
      // index advances against the count of the frame just finished
      if ({1'b0, quadro_q} >= num_quadros(estado_q) - 3'd1) quadro_d = 2'd0;
      else quadro_d = quadro_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= 4'(EST_IDLE);
      quadro_q <= 2'd0;
    end else begin
      estado_q <= estado_d;
      quadro_q <= quadro_d;
    end
  end

  assign estado_out = estado_q;
  assign quadro     = quadro_q;

endmodule

// File: rtl/escalonador_quadros.sv
// Frame scheduler: streams one image frame byte-by-byte from the image memory
// per tick. Define ESCALONADOR_OVERRUN_EN to count dropped ticks on overrun.
module escalonador_quadros
  import escalonador_pkg::*;
#(
  parameter int FRAME_BYTES = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        estado,
  input  logic              tick_quadro,
  output logic [3:0]        mem_estado,
  output logic [1:0]        mem_quadro,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              px_valid,
  output logic [7:0]        px_data,
  input  logic              px_ready,
  output logic              px_first,
  output logic              px_last,
  output logic              busy,
  output logic [7:0]        overrun
);

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(FRAME_BYTES - 1);

  fsm_e              fsm_q, fsm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        px_data_q, px_data_d;
  logic              px_valid_q, px_valid_d;
  logic              pendente_q, pendente_d;
  logic              inicio, avancar, ocupado;

  assign ocupado = (fsm_q != OCIOSO);

  always_comb begin
    fsm_d      = fsm_q;
    addr_d     = addr_q;
    px_data_d  = px_data_q;
    px_valid_d = px_valid_q;
    pendente_d = pendente_q;
    inicio     = 1'b0;
    avancar    = 1'b0;
    case (fsm_q)
      OCIOSO: if (tick_quadro || pendente_q) begin
        inicio     = 1'b1;
        pendente_d = 1'b0;
        addr_d     = '0;
        fsm_d      = LER;
      end
      LER: begin
        px_data_d  = mem_data;
        px_valid_d = 1'b1;
        fsm_d      = ENVIAR;
      end
      ENVIAR: if (px_ready) begin
        px_valid_d = 1'b0;
        if (addr_q == ULTIMO) begin
          avancar = 1'b1;
          fsm_d   = OCIOSO;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          fsm_d  = LER;
        end
      end
      default: fsm_d = OCIOSO;
    endcase
    // the last-byte cycle still counts as busy, so a tick there only queues
    if (ocupado && tick_quadro) pendente_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q      <= OCIOSO;
      addr_q     <= '0;
      px_data_q  <= 8'd0;
      px_valid_q <= 1'b0;
      pendente_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      addr_q     <= addr_d;
      px_data_q  <= px_data_d;
      px_valid_q <= px_valid_d;
      pendente_q <= pendente_d;
    end
  end

  contador_quadros u_contador (
    .clk        (clk),
    .rst_n      (rst_n),
    .inicio     (inicio),
    .avancar    (avancar),
    .estado_in  (saneia_estado(estado)),
    .estado_out (mem_estado),
    .quadro     (mem_quadro)
  );

`ifdef ESCALONADOR_OVERRUN_EN
  logic [7:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (ocupado && tick_quadro && pendente_q && overrun_q != 8'hFF)
      overrun_d = overrun_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) overrun_q <= 8'd0;
    else        overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 8'd0;
`endif

  assign mem_addr = addr_q;
  assign px_valid = px_valid_q;
  assign px_data  = px_data_q;
  assign px_first = px_valid_q && (addr_q == '0);
  assign px_last  = px_valid_q && (addr_q == ULTIMO);
  assign busy     = ocupado;

endmodule

// File: doc/escalonador_quadros.md
ESCALONADOR_QUADROS -- requirements
Module: escalonador_quadros

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 1024, bytes per image frame.
REQ-002 SHALL have parameter ADDR_W, default 10, byte-address width; FRAME_BYTES == 2**ADDR_W.
REQ-003 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: estado  in  4  pet state (IDLE=0, DORMINDO=1, COMENDO=2, DANDO_AULA=3, MORTO=4).
REQ-006 SHALL have ports: tick_quadro  in  1  one-cycle pulse requesting the next frame.
REQ-007 SHALL have ports: mem_estado  out  4  state selected for the image memory; mem_quadro  out  2  frame index; mem_addr  out  ADDR_W  byte address.
REQ-008 SHALL have ports: mem_data  in  8  byte returned exactly one cycle after mem_estado/mem_quadro/mem_addr are registered.
REQ-009 SHALL have ports: px_valid  out  1; px_data  out  8; px_ready  in  1; px_first  out  1 (byte 0); px_last  out  1 (byte FRAME_BYTES-1).
REQ-010 SHALL have ports: busy  out  1  frame in progress; overrun  out  8  dropped-tick count.

Function
REQ-011 SHALL implement FSM OCIOSO -> LER -> ENVIAR -> (LER | OCIOSO).
REQ-012 In OCIOSO, tick_quadro or pending flag SHALL latch estado into mem_estado, clear pending, zero mem_addr, enter LER; busy=1 from the next cycle.
REQ-013 estado values above 4 SHALL be latched as IDLE.
REQ-014 LER SHALL last exactly one cycle; at its end, mem_data SHALL be registered into px_data and px_valid asserted (ENVIAR).
REQ-015 px_valid, px_data, px_first, px_last SHALL hold stable until the cycle px_valid && px_ready.
REQ-016 On transfer of a non-last byte: mem_addr += 1, px_valid=0, enter LER; minimum 2 cycles/byte.
REQ-017 On transfer of the last byte (mem_addr == FRAME_BYTES-1): enter OCIOSO, busy=0, advance frame index.
REQ-018 Frame counts per state: IDLE 4, DORMINDO 2, COMENDO 3, DANDO_AULA 4, MORTO 1; index wraps to 0 after count-1.
REQ-019 If the latched estado differs from the previous frame's estado, mem_quadro SHALL restart at 0 for that frame.
REQ-020 estado changes while busy SHALL NOT affect the frame in progress.
REQ-021 tick_quadro while busy SHALL set pending (one deep); a tick while pending already set SHALL increment overrun (saturating at 255).
REQ-022 tick_quadro in the same cycle as the last-byte transfer SHALL set pending, not overrun.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force OCIOSO; px_valid, px_first, px_last, busy, pending = 0; mem_addr, mem_quadro, px_data, overrun = 0; mem_estado = IDLE.
REQ-024 Reset mid-frame SHALL abort without emitting px_last; the next frame starts at byte 0, frame 0.

Configuration
REQ-025 Macro ESCALONADOR_OVERRUN_EN defined: overrun counter per REQ-021.
REQ-026 Macro undefined: overrun tied to 0, no counter logic; the pending flag is still kept.

Structure
REQ-027 Package escalonador_pkg SHALL hold state encodings, the per-state frame-count table/function and the FSM state type.
REQ-028 Sub-module contador_quadros SHALL hold the frame index, last-estado register and the wrap logic.

Verification
REQ-029 Reset, estado=0, one tick, px_ready=1 -> 1024 bytes, px_first on byte 0, px_last on byte 1023, 2048 cycles, mem_quadro=0 then 1.
REQ-030 estado=DORMINDO, 3 full frames -> mem_quadro 0,1,0; estado=MORTO -> always 0.
REQ-031 px_ready low for 5 cycles at byte 10 -> px_data, px_valid and mem_addr held; no byte lost or duplicated.
REQ-032 Three ticks during one frame -> one extra frame runs, overrun=1 (0 with macro undefined).
REQ-033 estado 2 -> 3 mid-frame -> current frame keeps mem_estado=2; next frame mem_estado=3, mem_quadro=0.
REQ-034 rst_n low at byte 500 -> next cycle all outputs at reset values; next tick restarts at byte 0, frame 0.
